cmp_track: RTL and testbench

- Parametrised, pipelined successor to the board-level two-operand comparator.
- On each edge-detected load strobe, captures operands A and B in signed or unsigned mode. Produces registered greater/less/equal flags and sign-magnitude forms of both operands for the HEX display drivers.
- Also keeps running statistics: min/max of A, plus saturating counts of GT, LT and EQ outcomes.
- Sits between the switch/key synchroniser and the seven-segment/LED drivers.

---
 rtl/cmp_track_pkg.sv | 29 ++
 rtl/cmp_sign_mag.sv | 23 ++
 rtl/cmp_track.sv | 166 ++++++++++++++++
 tb/tb_cmp_track.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_track_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_track_pkg
// Purpose  : Shared encodings and the mode-aware ordering helper for cmp_track.
// Revision : 1.0 - initial release
// ============================================================================
package cmp_track_pkg;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    localparam logic [1:0] CMP_GT = 2'd0;
    localparam logic [1:0] CMP_LT = 2'd1;
    localparam logic [1:0] CMP_EQ = 2'd2;

    // Callers extend their WIDTH-bit operands to this width in the matching mode.
    localparam int CMP_MAX_W = 64;

    function automatic logic cmp_less(input logic [CMP_MAX_W-1:0] a,
                                      input logic [CMP_MAX_W-1:0] b,
                                      input logic                 signed_mode);
        if (signed_mode == MODE_SIGNED)
            cmp_less = ($signed(a) < $signed(b));
        else
            cmp_less = (a < b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_sign_mag.sv
`default_nettype none
// ============================================================================
// Module   : cmp_sign_mag
// Purpose  : Combinational sign/magnitude split of one operand for display.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_sign_mag
    import cmp_track_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] value,
    input  logic             mode_signed,
    output logic             neg,
    output logic [WIDTH-1:0] mag
);

    // The most negative value negates to itself, which reads correctly as unsigned.
    assign neg = (mode_signed == MODE_SIGNED) & value[WIDTH-1];
    assign mag = neg ? (~value + WIDTH'(1)) : value;

endmodule
`default_nettype wire

// File: rtl/cmp_track.sv
`default_nettype none
// ============================================================================
// Module   : cmp_track
// Purpose  : Two-stage signed/unsigned comparator with running min/max of A
//            and saturating GT/LT/EQ outcome counters.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_track
    import cmp_track_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_signed,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             valid,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             a_neg,
    output logic             b_neg,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] min_a,
    output logic [WIDTH-1:0] max_a,
    output logic             stats_valid,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic             r_load_q;
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_mode;
    logic             r_prev_mode;

    logic             w_load_edge;
    logic             w_lt;
    logic             w_eq;
    logic [1:0]       w_outcome;
    logic             w_restart;
    logic             w_new_min;
    logic             w_new_max;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    function automatic logic [CMP_MAX_W-1:0] f_ext(input logic [WIDTH-1:0] v,
                                                   input logic             s);
        f_ext = (s == MODE_SIGNED) ? CMP_MAX_W'($signed(v)) : CMP_MAX_W'(v);
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        f_sat_inc = (c == c_cnt_max) ? c : c + c_cnt_one;
    endfunction

    assign w_load_edge = load & ~r_load_q;

    assign w_lt = cmp_less(f_ext(r_s1_a, r_s1_mode), f_ext(r_s1_b, r_s1_mode), r_s1_mode);
    assign w_eq = (r_s1_a == r_s1_b);

    always_comb begin
        w_outcome = CMP_GT;
        if (w_eq)
            w_outcome = CMP_EQ;
        else if (w_lt)
            w_outcome = CMP_LT;
    end

    // A clear in the same cycle as a result makes that result the first of a new set.
    assign w_restart = clr | ~stats_valid | (r_s1_mode != r_prev_mode);
    assign w_new_min = cmp_less(f_ext(r_s1_a, r_s1_mode), f_ext(min_a, r_s1_mode), r_s1_mode);
    assign w_new_max = cmp_less(f_ext(max_a, r_s1_mode), f_ext(r_s1_a, r_s1_mode), r_s1_mode);

    cmp_sign_mag #(.WIDTH(WIDTH)) u_sm_a (
        .value       (r_s1_a),
        .mode_signed (r_s1_mode),
        .neg         (w_a_neg),
        .mag         (w_a_mag)
    );

    cmp_sign_mag #(.WIDTH(WIDTH)) u_sm_b (
        .value       (r_s1_b),
        .mode_signed (r_s1_mode),
        .neg         (w_b_neg),
        .mag         (w_b_mag)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_q    <= 1'b1;
            r_s1_vld    <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_mode   <= MODE_UNSIGNED;
            r_prev_mode <= MODE_UNSIGNED;
            valid       <= 1'b0;
            a_gt_b      <= 1'b0;
            a_lt_b      <= 1'b0;
            a_eq_b      <= 1'b0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            a_mag       <= '0;
            b_mag       <= '0;
            min_a       <= '0;
            max_a       <= '0;
            stats_valid <= 1'b0;
            gt_cnt      <= '0;
            lt_cnt      <= '0;
            eq_cnt      <= '0;
        end else begin
            r_load_q <= load;
            r_s1_vld <= w_load_edge;
            valid    <= r_s1_vld;
            if (w_load_edge) begin
                r_s1_a    <= a_in;
                r_s1_b    <= b_in;
                r_s1_mode <= mode_signed;
            end
            if (r_s1_vld) begin
                a_gt_b      <= (w_outcome == CMP_GT);
                a_lt_b      <= (w_outcome == CMP_LT);
                a_eq_b      <= (w_outcome == CMP_EQ);
                a_neg       <= w_a_neg;
                b_neg       <= w_b_neg;
                a_mag       <= w_a_mag;
                b_mag       <= w_b_mag;
                r_prev_mode <= r_s1_mode;
                stats_valid <= 1'b1;
                if (w_restart) begin
                    min_a  <= r_s1_a;
                    max_a  <= r_s1_a;
                    gt_cnt <= (w_outcome == CMP_GT) ? c_cnt_one : '0;
                    lt_cnt <= (w_outcome == CMP_LT) ? c_cnt_one : '0;
                    eq_cnt <= (w_outcome == CMP_EQ) ? c_cnt_one : '0;
                end else begin
                    if (w_new_min) min_a <= r_s1_a;
                    if (w_new_max) max_a <= r_s1_a;
                    if (w_outcome == CMP_GT) gt_cnt <= f_sat_inc(gt_cnt);
                    if (w_outcome == CMP_LT) lt_cnt <= f_sat_inc(lt_cnt);
                    if (w_outcome == CMP_EQ) eq_cnt <= f_sat_inc(eq_cnt);
                end
            end else if (clr) begin
                min_a       <= '0;
                max_a       <= '0;
                stats_valid <= 1'b0;
                gt_cnt      <= '0;
                lt_cnt      <= '0;
                eq_cnt      <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_track.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_track
// Purpose  : Directed, table-driven self-checking bench for cmp_track
//            (WIDTH=4, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_track;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode_signed;
    logic          load;
    logic          clr;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          valid;
    logic          a_gt_b;
    logic          a_lt_b;
    logic          a_eq_b;
    logic          a_neg;
    logic          b_neg;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W-1:0]  min_a;
    logic [W-1:0]  max_a;
    logic          stats_valid;
    logic [CW-1:0] gt_cnt;
    logic [CW-1:0] lt_cnt;
    logic [CW-1:0] eq_cnt;

    int n_pass  = 0;
    int n_total = 0;

    cmp_track #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_signed (mode_signed),
        .load        (load),
        .clr         (clr),
        .a_in        (a_in),
        .b_in        (b_in),
        .valid       (valid),
        .a_gt_b      (a_gt_b),
        .a_lt_b      (a_lt_b),
        .a_eq_b      (a_eq_b),
        .a_neg       (a_neg),
        .b_neg       (b_neg),
        .a_mag       (a_mag),
        .b_mag       (b_mag),
        .min_a       (min_a),
        .max_a       (max_a),
        .stats_valid (stats_valid),
        .gt_cnt      (gt_cnt),
        .lt_cnt      (lt_cnt),
        .eq_cnt      (eq_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        logic [2:0]   flags;   // {gt, lt, eq}
        logic         an;
        logic [W-1:0] am;
        logic         bn;
        logic [W-1:0] bm;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load edge, then the result two edges later.
    task automatic samp(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input string tag);
        a_in = a; b_in = b; mode_signed = m; load = 1'b1;
        tick();
        load = 1'b0;
        chk({tag, ".valid_early"}, 32'(valid), 32'd0);
        tick();
        chk({tag, ".valid"}, 32'(valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        samp(v.a, v.b, v.m, tag);
        chk({tag, ".flags"}, 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(v.flags));
        chk({tag, ".a_neg"}, 32'(a_neg), 32'(v.an));
        chk({tag, ".a_mag"}, 32'(a_mag), 32'(v.am));
        chk({tag, ".b_neg"}, 32'(b_neg), 32'(v.bn));
        chk({tag, ".b_mag"}, 32'(b_mag), 32'(v.bm));
    endtask

    task automatic chk_stats(input string tag, input logic sv, input logic [W-1:0] mn,
                             input logic [W-1:0] mx, input logic [CW-1:0] g,
                             input logic [CW-1:0] l, input logic [CW-1:0] e);
        chk({tag, ".stats_valid"}, 32'(stats_valid), 32'(sv));
        chk({tag, ".min_a"}, 32'(min_a), 32'(mn));
        chk({tag, ".max_a"}, 32'(max_a), 32'(mx));
        chk({tag, ".gt_cnt"}, 32'(gt_cnt), 32'(g));
        chk({tag, ".lt_cnt"}, 32'(lt_cnt), 32'(l));
        chk({tag, ".eq_cnt"}, 32'(eq_cnt), 32'(e));
    endtask

    initial begin
        //           a        b        m     flags   an    am       bn    bm
        tv[0]  = '{4'b1000, 4'b0111, 1'b1, 3'b010, 1'b1, 4'b1000, 1'b0, 4'b0111};
        tv[1]  = '{4'b1000, 4'b0111, 1'b0, 3'b100, 1'b0, 4'b1000, 1'b0, 4'b0111};
        tv[2]  = '{4'b1101, 4'b1111, 1'b1, 3'b010, 1'b1, 4'b0011, 1'b1, 4'b0001};
        tv[3]  = '{4'b1101, 4'b1111, 1'b0, 3'b010, 1'b0, 4'b1101, 1'b0, 4'b1111};
        tv[4]  = '{4'b0101, 4'b0101, 1'b1, 3'b001, 1'b0, 4'b0101, 1'b0, 4'b0101};
        tv[5]  = '{4'b0010, 4'b1110, 1'b1, 3'b100, 1'b0, 4'b0010, 1'b1, 4'b0010};
        tv[6]  = '{4'b0000, 4'b1111, 1'b0, 3'b010, 1'b0, 4'b0000, 1'b0, 4'b1111};
        tv[7]  = '{4'b1111, 4'b1000, 1'b1, 3'b100, 1'b1, 4'b0001, 1'b1, 4'b1000};
        // back-to-back unsigned burst
        tv[8]  = '{4'd1,  4'd2,  1'b0, 3'b010, 1'b0, 4'd1,  1'b0, 4'd2};
        tv[9]  = '{4'd2,  4'd1,  1'b0, 3'b100, 1'b0, 4'd2,  1'b0, 4'd1};
        tv[10] = '{4'd3,  4'd3,  1'b0, 3'b001, 1'b0, 4'd3,  1'b0, 4'd3};
        tv[11] = '{4'd15, 4'd0,  1'b0, 3'b100, 1'b0, 4'd15, 1'b0, 4'd0};
        tv[12] = '{4'd0,  4'd15, 1'b0, 3'b010, 1'b0, 4'd0,  1'b0, 4'd15};
        tv[13] = '{4'd7,  4'd8,  1'b0, 3'b010, 1'b0, 4'd7,  1'b0, 4'd8};
        tv[14] = '{4'd8,  4'd7,  1'b0, 3'b100, 1'b0, 4'd8,  1'b0, 4'd7};
        tv[15] = '{4'd9,  4'd9,  1'b0, 3'b001, 1'b0, 4'd9,  1'b0, 4'd9};
        tv[16] = '{4'd12, 4'd4,  1'b0, 3'b100, 1'b0, 4'd12, 1'b0, 4'd4};
        tv[17] = '{4'd4,  4'd12, 1'b0, 3'b010, 1'b0, 4'd4,  1'b0, 4'd12};

        // Reset with load held high
        rst_n = 1'b0; load = 1'b1; clr = 1'b0; mode_signed = 1'b0; a_in = '0; b_in = '0;
        repeat (3) tick();
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'd0);
        chk("rst.signmag", 32'({a_neg, b_neg, a_mag, b_mag}), 32'd0);
        chk_stats("rst", 1'b0, '0, '0, '0, '0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rel%0d.valid", i), 32'(valid), 32'd0);
        end
        load = 1'b0;
        tick();
        samp(4'd0, 4'd0, 1'b0, "first");
        chk("first.flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b001);
        chk_stats("first", 1'b1, 4'd0, 4'd0, 2'd0, 2'd0, 2'd1);
        tick();
        chk("first.valid_drop", 32'(valid), 32'd0);

        // Compare / sign-magnitude table
        for (int i = 0; i < 8; i++)
            run_vec(tv[i], $sformatf("v%0d", i));

        // clr leaves the compare outputs alone
        clr = 1'b1; tick(); clr = 1'b0;
        chk_stats("clr", 1'b0, '0, '0, '0, '0, '0);
        chk("clr.flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b100);
        chk("clr.a_mag", 32'(a_mag), 32'b0001);

        // Signed running statistics
        samp(4'b0011, 4'b0000, 1'b1, "s0");
        samp(4'b1101, 4'b0000, 1'b1, "s1");
        chk("s1.flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b010);
        samp(4'b0110, 4'b0000, 1'b1, "s2");
        chk_stats("sgn", 1'b1, 4'b1101, 4'b0110, 2'd2, 2'd1, 2'd0);

        // Mode switch restarts statistics; unsigned ordering afterwards
        samp(4'b0001, 4'b0001, 1'b0, "m0");
        chk_stats("msw", 1'b1, 4'b0001, 4'b0001, 2'd0, 2'd0, 2'd1);
        samp(4'b1001, 4'b0000, 1'b0, "m1");
        chk_stats("uns", 1'b1, 4'b0001, 4'b1001, 2'd1, 2'd0, 2'd1);

        // Mode toggling without a load edge changes nothing
        mode_signed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("tog%0d.valid", i), 32'(valid), 32'd0);
        end
        mode_signed = 1'b0;
        tick();
        chk("tog.a_neg", 32'(a_neg), 32'd0);
        chk("tog.a_mag", 32'(a_mag), 32'b1001);
        chk("tog.flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b100);
        chk_stats("tog", 1'b1, 4'b0001, 4'b1001, 2'd1, 2'd0, 2'd1);

        // Saturation of a 2-bit counter
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            samp(4'b0100, 4'b0100, 1'b1, $sformatf("sat%0d", i));
            chk($sformatf("sat%0d.eq_cnt", i), 32'(eq_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        // clr coinciding with the stage-2 update
        a_in = 4'b1010; b_in = 4'b1010; mode_signed = 1'b1; load = 1'b1;
        tick();
        load = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrhit.valid", 32'(valid), 32'd1);
        chk_stats("clrhit", 1'b1, 4'b1010, 4'b1010, 2'd0, 2'd0, 2'd1);

        // Back-to-back loads, one every other cycle
        for (int i = 8; i < 18; i++)
            run_vec(tv[i], $sformatf("b2b%0d", i - 8));
        chk_stats("b2b", 1'b1, 4'd0, 4'd15, 2'd3, 2'd3, 2'd2);

        // Reset drops an in-flight sample
        a_in = 4'd5; b_in = 4'd6; mode_signed = 1'b0; load = 1'b1;
        tick();
        rst_n = 1'b0; load = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst.valid", 32'(valid), 32'd0);
        tick();
        chk("midrst.valid2", 32'(valid), 32'd0);
        chk_stats("midrst", 1'b0, '0, '0, '0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
